// File: rtl/fp_stream_pkg.sv
// rtl/fp_stream_pkg.sv - shared width, playback state encoding and handshake helper
package fp_stream_pkg;

  localparam int FP_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic xfer(input logic stb, input logic ack);
    return stb & ack;
  endfunction

endpackage

// File: rtl/stream_vector_ram.sv
// rtl/stream_vector_ram.sv - DEPTH x 64 single-port vector table, registered read
// A write also updates the read register, so a same-cycle write is what the next read sees.
module stream_vector_ram
  import fp_stream_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [FP_WIDTH-1:0] wdata_i,
  output logic [FP_WIDTH-1:0] rdata_o
);

  logic [FP_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/double_stream_source.sv
// rtl/double_stream_source.sv - plays a preloaded 64-bit vector table out on a stb/ack stream
// FETCH issues the table read, SEND holds stb until ack, WAIT inserts GAP idle cycles.
module double_stream_source
  import fp_stream_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int GAP   = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_we,
  input  logic [AW-1:0]       load_addr,
  input  logic [FP_WIDTH-1:0] load_data,
  input  logic [AW:0]         length,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         sent_count,
  output logic [FP_WIDTH-1:0] output_z,
  output logic                output_z_stb,
  input  logic                output_z_ack
);

  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [7:0]  GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  state_t              state_q;
  logic [AW:0]         len_q, sent_q, len_d, sent_d;
  logic [AW-1:0]       idx_q, ram_addr;
  logic [7:0]          gap_q;
  logic                stb_q, busy_q, done_q;
  logic                idle_like, ram_we;
  logic [FP_WIDTH-1:0] ram_rdata;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ram_we    = idle_like & load_we;
  assign ram_addr  = ram_we ? load_addr : idx_q;
  assign len_d     = (length > DEPTH_W) ? DEPTH_W : length;
  assign sent_d    = sent_q + (AW+1)'(1);

  stream_vector_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (load_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sent_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q  <= len_d;
            sent_q <= '0;
            idx_q  <= '0;
            if (len_d == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          state_q <= ST_SEND;
          stb_q   <= 1'b1;
        end
        ST_SEND: begin
          if (xfer(stb_q, output_z_ack)) begin
            stb_q  <= 1'b0;
            sent_q <= sent_d;
            idx_q  <= idx_q + AW'(1);
            if (sent_d == len_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP == 0) begin
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_WAIT;
              gap_q   <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (gap_q == GAP_LAST) state_q <= ST_FETCH;
          else                   gap_q   <= gap_q + 8'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The read register is not reset; masking with stb gives a zero output outside SEND.
  assign output_z     = stb_q ? ram_rdata : '0;
  assign output_z_stb = stb_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sent_count   = sent_q;

endmodule

// File: tb/tb_double_stream_source.sv
// tb/tb_double_stream_source.sv - randomized self-checking bench for double_stream_source
module tb_double_stream_source;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst, load_we, start0, start3, ack0, ack3;
  logic [AW-1:0] load_addr;
  logic [63:0] load_data;
  logic [AW:0] length;
  logic        busy0, done0, stb0, busy3, done3, stb3;
  logic [AW:0] sent0, sent3;
  logic [63:0] z0, z3;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] got_w[$];
  int          got_c[$];
  int          hold_err, stb_hi, n_checks, n_pass;
  bit          timed_out;

  always #5 clk = ~clk;

  double_stream_source #(.DEPTH(DEPTH), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .length(length), .start(start0), .busy(busy0), .done(done0), .sent_count(sent0),
    .output_z(z0), .output_z_stb(stb0), .output_z_ack(ack0));

  double_stream_source #(.DEPTH(DEPTH), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .length(length), .start(start3), .busy(busy3), .done(done3), .sent_count(sent3),
    .output_z(z3), .output_z_stb(stb3), .output_z_ack(ack3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [63:0] d);
    load_we = 1'b1; load_addr = AW'(a); load_data = d;
    step();
    load_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) load(i, {$urandom, $urandom});
  endtask

  task automatic start_play(input bit sel, input int len);
    length = (AW+1)'(len);
    if (sel) start3 = 1'b1; else start0 = 1'b1;
    step();
    start0 = 1'b0; start3 = 1'b0;
  endtask

  // Observes one playback until done; records accepted words and the cycle they were accepted in.
  task automatic play(input bit sel, input bit rnd_ack, input int budget);
    logic s, d, a, prev_stb, prev_acc;
    logic [63:0] z, prev_z;
    got_w.delete(); got_c.delete();
    hold_err = 0; stb_hi = 0; timed_out = 1'b1;
    prev_stb = 1'b0; prev_acc = 1'b0; prev_z = '0;
    for (int c = 0; c < budget; c++) begin
      a = rnd_ack ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (sel) ack3 = a; else ack0 = a;
      s = sel ? stb3 : stb0;
      z = sel ? z3 : z0;
      d = sel ? done3 : done0;
      if (d) begin
        timed_out = 1'b0;
        return;
      end
      if (prev_stb && !prev_acc && (!s || z !== prev_z)) hold_err++;
      if (s) stb_hi++;
      if (s && a) begin
        got_w.push_back(z);
        got_c.push_back(c);
      end
      prev_stb = s; prev_acc = s && a; prev_z = z;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({stb0, busy0, done0, sent0, z0, stb3, busy3, done3, sent3, z3} !== '0)
      $display("FAIL reset_outputs: stb=%b busy=%b done=%b sent=%0d z=%h required all zero",
               stb0, busy0, done0, sent0, z0);
    else n_pass++;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    load(0, 64'h3FF0000000000000);
    load(1, 64'h4000000000000000);
    ack0 = 1'b1;
    start_play(0, 2);
    n_checks++;
    if (stb0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL basic_fetch: stb=%b busy=%b required 0 1", stb0, busy0);
    else n_pass++;
    play(0, 0, 50);
    n_checks++;
    if (timed_out || got_w.size() != 2) $display("FAIL basic_count: got %0d words timeout=%0b required 2", got_w.size(), timed_out);
    else n_pass++;
    if (got_w.size() == 2) begin
      n_checks++;
      if (got_w[0] !== 64'h3FF0000000000000 || got_w[1] !== 64'h4000000000000000)
        $display("FAIL basic_data: got %h %h required 3ff0.. 4000..", got_w[0], got_w[1]);
      else n_pass++;
      n_checks++;
      if (got_c[0] != 1 || got_c[1] - got_c[0] != 2)
        $display("FAIL basic_timing: first=%0d spacing=%0d required 1 2", got_c[0], got_c[1] - got_c[0]);
      else n_pass++;
    end
    n_checks++;
    if (done0 !== 1'b1 || sent0 !== 5'd2 || busy0 !== 1'b0)
      $display("FAIL basic_done: done=%b sent=%0d busy=%b required 1 2 0", done0, sent0, busy0);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    start_play(0, 0);
    n_checks++;
    if (done0 !== 1'b1 || stb0 !== 1'b0 || sent0 !== '0 || busy0 !== 1'b0)
      $display("FAIL zero_len: done=%b stb=%b sent=%0d busy=%b required 1 0 0 0", done0, stb0, sent0, busy0);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (stb0 !== 1'b0) $display("FAIL zero_len_stb: stb=%b required 0", stb0);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    fill(4);
    ack0 = 1'b0;
    start_play(0, 3);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stb0) begin ok = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!ok) $display("FAIL bp_stb_rise: stb=%b required 1", stb0);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      step();
      n_checks++;
      if (stb0 !== 1'b1 || z0 !== model_mem[0] || sent0 !== '0)
        $display("FAIL bp_hold: stb=%b z=%h sent=%0d required 1 %h 0", stb0, z0, sent0, model_mem[0]);
      else n_pass++;
    end
    ack0 = 1'b1;
    step();
    n_checks++;
    if (sent0 !== 5'd1 || stb0 !== 1'b0) $display("FAIL bp_accept: sent=%0d stb=%b required 1 0", sent0, stb0);
    else n_pass++;
    play(0, 0, 50);
    n_checks++;
    if (timed_out || got_w.size() != 2 || got_w[0] !== model_mem[1] || got_w[1] !== model_mem[2] || sent0 !== 5'd3)
      $display("FAIL bp_rest: words=%0d sent=%0d timeout=%0b required 2 3 0", got_w.size(), sent0, timed_out);
    else n_pass++;
  endtask

  task automatic test_gap();
    fill(4);
    ack3 = 1'b1;
    start_play(1, 4);
    play(1, 0, 100);
    n_checks++;
    if (timed_out || got_w.size() != 4 || stb_hi != 4)
      $display("FAIL gap_count: words=%0d stb_cycles=%0d timeout=%0b required 4 4 0", got_w.size(), stb_hi, timed_out);
    else n_pass++;
    for (int i = 0; i < got_w.size(); i++) begin
      n_checks++;
      if (got_w[i] !== model_mem[i] || (i > 0 && got_c[i] - got_c[i-1] != 5))
        $display("FAIL gap_word%0d: z=%h spacing=%0d required %h 5", i, got_w[i],
                 (i > 0) ? got_c[i] - got_c[i-1] : 5, model_mem[i]);
      else n_pass++;
    end
    n_checks++;
    if (done3 !== 1'b1 || sent3 !== 5'd4) $display("FAIL gap_done: done=%b sent=%0d required 1 4", done3, sent3);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    logic [63:0] nv;
    nv = {$urandom, $urandom};
    load_we = 1'b1; load_addr = '0; load_data = nv;
    length = 5'd1; start0 = 1'b1;
    step();
    load_we = 1'b0; start0 = 1'b0;
    model_mem[0] = nv;
    play(0, 0, 50);
    n_checks++;
    if (timed_out || got_w.size() != 1 || got_w[0] !== nv)
      $display("FAIL same_cycle: words=%0d z=%h required 1 %h", got_w.size(), (got_w.size() > 0) ? got_w[0] : 64'h0, nv);
    else n_pass++;
  endtask

  task automatic test_ignored();
    bit ok;
    fill(4);
    ack0 = 1'b0;
    start_play(0, 4);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stb0) begin ok = 1'b1; break; end
      step();
    end
    load_we = 1'b1; load_addr = 4'd1; load_data = ~model_mem[1];
    length = 5'd2; start0 = 1'b1;
    step();
    load_we = 1'b0; start0 = 1'b0;
    n_checks++;
    if (!ok || stb0 !== 1'b1 || busy0 !== 1'b1 || sent0 !== '0)
      $display("FAIL ign_state: stb=%b busy=%b sent=%0d required 1 1 0", stb0, busy0, sent0);
    else n_pass++;
    play(0, 1, 200);
    n_checks++;
    if (timed_out || got_w.size() != 4 || hold_err != 0)
      $display("FAIL ign_length: words=%0d hold_err=%0d required 4 0", got_w.size(), hold_err);
    else n_pass++;
    for (int i = 0; i < got_w.size(); i++) begin
      n_checks++;
      if (got_w[i] !== model_mem[i]) $display("FAIL ign_word%0d: z=%h required %h", i, got_w[i], model_mem[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int len, exp_n, bad;
    for (int r = 0; r < 4; r++) begin
      fill(DEPTH);
      len = (r == 0) ? DEPTH : $urandom_range(1, 2 * DEPTH - 1);
      exp_n = (len > DEPTH) ? DEPTH : len;
      start_play(0, len);
      play(0, 1, 600);
      bad = 0;
      for (int i = 0; i < got_w.size(); i++) if (got_w[i] !== model_mem[i % DEPTH]) bad++;
      n_checks++;
      if (timed_out || got_w.size() != exp_n || bad != 0 || hold_err != 0 || sent0 !== (AW+1)'(exp_n))
        $display("FAIL rand_run%0d: len=%0d words=%0d sent=%0d bad=%0d hold_err=%0d required %0d words", r, len,
                 got_w.size(), sent0, bad, hold_err, exp_n);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill(4);
    ack0 = 1'b1;
    start_play(0, 4);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stb0 && sent0 == 5'd1) begin ok = 1'b1; break; end
      step();
    end
    ack0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!ok || stb0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || sent0 !== '0 || z0 !== '0)
      $display("FAIL rst_mid: reached=%0b stb=%b busy=%b done=%b sent=%0d required 1 0 0 0 0", ok, stb0, busy0, done0, sent0);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    ack0 = 1'b1;
    start_play(0, 2);
    play(0, 0, 50);
    n_checks++;
    if (timed_out || got_w.size() != 2 || got_w[0] !== model_mem[0] || got_w[1] !== model_mem[1])
      $display("FAIL rst_replay: words=%0d required 2 from index 0", got_w.size());
    else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    load_we = 1'b0; load_addr = '0; load_data = '0; length = '0;
    start0 = 1'b0; start3 = 1'b0; ack0 = 1'b1; ack3 = 1'b1;
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_gap();
    test_same_cycle();
    test_ignored();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
